// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage data-memory access path:
// FSM encoding, data-memory map defaults and bus error codes.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  localparam logic [31:0] DMEM_BASE    = 32'd1024;
  localparam int          DMEM_ADDR_W  = 8;
  localparam int          DMEM_TIMEOUT = 16;

  localparam logic BUS_OK  = 1'b0;
  localparam logic BUS_ERR = 1'b1;

endpackage

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory initiator: turns load/store enables into a req/ack
// transaction, freezes the pipeline until it completes, then pulses ready.
module mem_access_ctrl
  import mips_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DMEM_BASE,
  parameter int          ADDR_W    = DMEM_ADDR_W,
  parameter int          TIMEOUT   = DMEM_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MEM_R_EN_in,
  input  logic              MEM_W_EN_in,
  input  logic [31:0]       ALU_result_in,
  input  logic [31:0]       Val_Rm_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       MEM_read_value,
  output logic              ready,
  output logic              freeze,
  output logic              bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  mem_state_e        state_q, state_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdval_q, rdval_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              access_en;
  logic              misaligned;
  logic [ADDR_W-1:0] word_addr;

  assign access_en  = MEM_R_EN_in | MEM_W_EN_in;
  assign misaligned = (ALU_result_in[1:0] != 2'b00);
  // Addresses below the base simply wrap into the top of the word space.
  assign word_addr  = ADDR_W'((ALU_result_in - BASE_ADDR) >> 2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdval_q <= '0;
      err_q   <= BUS_OK;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdval_q <= rdval_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdval_d = rdval_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    freeze  = 1'b0;
    ready   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (access_en) begin
          freeze = 1'b1;
          if (misaligned) begin
            err_d   = BUS_ERR;
            rdval_d = '0;
            state_d = DONE;
          end else begin
            req_d   = 1'b1;
            we_d    = ~MEM_R_EN_in & MEM_W_EN_in;
            addr_d  = word_addr;
            wdata_d = Val_Rm_in;
            cnt_d   = '0;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        freeze = 1'b1;
        // An ack on the final allowed cycle still wins over the timeout.
        if (mem_ack) begin
          req_d   = 1'b0;
          if (!we_q) rdval_d = mem_rdata;
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          err_d   = BUS_ERR;
          rdval_d = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req        = req_q;
  assign mem_we         = we_q;
  assign mem_addr       = addr_q;
  assign mem_wdata      = wdata_q;
  assign MEM_read_value = rdval_q;
  assign bus_err        = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus randomized transactions
// predicted per transaction from address, enables and ack latency.
module tb_mem_access_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        r_en, w_en;
  logic [31:0] alu, val_rm;
  logic        mem_req, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] rd_val;
  logic        ready, freeze, bus_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_rd;
  logic        exp_err;

  mem_access_ctrl dut (
    .clk(clk), .rst(rst),
    .MEM_R_EN_in(r_en), .MEM_W_EN_in(w_en),
    .ALU_result_in(alu), .Val_Rm_in(val_rm),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .MEM_read_value(rd_val), .ready(ready), .freeze(freeze), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] model_addr(input logic [31:0] a);
    return 8'(((a - 32'd1024) / 32'd4) % 32'd256);
  endfunction

  task automatic check_idle(input string tag);
    check_val({tag, "_freeze"}, freeze, 0);
    check_val({tag, "_ready"}, ready, 0);
    check_val({tag, "_req"}, mem_req, 0);
    check_val({tag, "_rdval"}, rd_val, exp_rd);
    check_val({tag, "_err"}, bus_err, exp_err);
  endtask

  // k = WAIT cycle (1-based) on which ack is given; k > TIMEOUT means never.
  task automatic do_txn(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] wd, input int k, input logic [31:0] rd);
    logic mis;
    int   n;
    mis = (a % 4) != 0;
    n   = (k > TIMEOUT) ? TIMEOUT : k;
    @(negedge clk);
    r_en = r; w_en = w; alu = a; val_rm = wd; mem_ack = 1'b0; mem_rdata = $urandom;
    #1;
    check_val("issue_freeze", freeze, 1);
    check_val("issue_req", mem_req, 0);
    check_val("issue_ready", ready, 0);
    if (mis) begin
      exp_err = 1'b1;
      exp_rd  = 32'd0;
    end else begin
      for (int wc = 1; wc <= n; wc++) begin
        @(negedge clk);
        mem_ack   = (wc == k);
        mem_rdata = (wc == k) ? rd : $urandom;
        #1;
        check_val("wait_req", mem_req, 1);
        check_val("wait_freeze", freeze, 1);
        check_val("wait_ready", ready, 0);
        check_val("wait_addr", mem_addr, model_addr(a));
        check_val("wait_we", mem_we, (!r && w) ? 1 : 0);
        check_val("wait_wdata", mem_wdata, wd);
      end
      if (k > TIMEOUT) begin
        exp_err = 1'b1;
        exp_rd  = 32'd0;
      end else if (r) begin
        exp_rd = rd;
      end
    end
    // Completion cycle: enables still held, a stray ack must be ignored.
    @(negedge clk);
    mem_ack = 1'($urandom); mem_rdata = $urandom;
    #1;
    check_val("done_ready", ready, 1);
    check_val("done_freeze", freeze, 0);
    check_val("done_req", mem_req, 0);
    check_val("done_rdval", rd_val, exp_rd);
    check_val("done_err", bus_err, exp_err);
    @(negedge clk);
    r_en = 1'b0; w_en = 1'b0; mem_ack = 1'b0;
    #1;
    check_idle("after");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; r_en = 1'b0; w_en = 1'b0; mem_ack = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_rd = 32'd0; exp_err = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    int          k;
    logic        r, w;
    rst = 1'b1; r_en = 1'b0; w_en = 1'b0; alu = '0; val_rm = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    exp_rd = 32'd0; exp_err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle("reset");
    check_val("reset_we", mem_we, 0);
    check_val("reset_addr", mem_addr, 0);
    check_val("reset_wdata", mem_wdata, 0);

    // Directed scenarios
    do_txn(1'b1, 1'b0, 32'd1028, 32'h0, 3, 32'hCAFE_0001);
    do_txn(1'b0, 1'b1, 32'd1032, 32'h1234, 1, 32'hDEAD_BEEF);
    check_val("store_keeps_rdval", rd_val, 32'hCAFE_0001);
    do_txn(1'b1, 1'b1, 32'd1024, 32'h5555, 2, 32'h0BAD_F00D);
    do_txn(1'b1, 1'b0, 32'd1036, 32'h0, TIMEOUT, 32'h7777_0000);
    do_txn(1'b1, 1'b0, 32'd1000, 32'h0, 1, 32'h1111_2222);
    do_txn(1'b1, 1'b0, 32'd1030, 32'h0, 1, 32'h0);
    do_reset();
    do_txn(1'b1, 1'b0, 32'd1040, 32'h0, TIMEOUT + 1, 32'h0);

    // Reset in the second WAIT cycle, then a late ack
    do_reset();
    @(negedge clk);
    r_en = 1'b1; w_en = 1'b0; alu = 32'd1044; mem_rdata = 32'hABCD_0000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; r_en = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    exp_rd = 32'd0; exp_err = 1'b0;
    #1;
    check_idle("rst_mid");
    check_val("rst_mid_we", mem_we, 0);
    check_val("rst_mid_addr", mem_addr, 0);
    check_val("rst_mid_wdata", mem_wdata, 0);
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check_idle("late_ack");

    // Randomized transactions with random idle gaps and stray acks
    for (int i = 0; i < 60; i++) begin
      if ((i % 15) == 0) do_reset();
      r = 1'($urandom);
      w = r ? 1'($urandom) : 1'b1;
      a = 32'd1024 + 32'($urandom_range(0, 2047)) - 32'd256;
      if ($urandom_range(0, 3) != 0) a = a & ~32'd3;
      k = $urandom_range(1, TIMEOUT + 2);
      do_txn(r, w, a, $urandom, k, $urandom);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        @(negedge clk);
        mem_ack = 1'($urandom); mem_rdata = $urandom;
        #1;
        check_idle("gap");
      end
      @(negedge clk);
      mem_ack = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- MEM-stage data-memory initiator; sits between the EX/MEM pipeline register and the external data memory.
- Converts the per-instruction read/write enables into a req/ack transaction on the data memory.
- Holds the pipeline with freeze until the transaction completes.
- Presents the read value and its companion control bits, stable, to the MEM/WB register on the cycle the pipeline advances.

Parameters:
- BASE_ADDR, 32'd1024, byte address mapped to data-memory word 0.
- ADDR_W, 8, word-address width driven to memory.
- TIMEOUT, 16, max WAIT cycles before abandoning an access.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- MEM_R_EN_in  in  1  load request from EX/MEM.
- MEM_W_EN_in  in  1  store request from EX/MEM.
- ALU_result_in  in  32  byte address.
- Val_Rm_in  in  32  store data.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  1 = write, valid with mem_req.
- mem_addr  out  ADDR_W  word address, valid with mem_req.
- mem_wdata  out  32  store data, valid with mem_req.
- mem_ack  in  1  one-cycle completion pulse from memory.
- mem_rdata  in  32  read data, valid with mem_ack.
- MEM_read_value  out  32  load result to MEM/WB register.
- ready  out  1  access complete this cycle; MEM/WB may capture.
- freeze  out  1  combinational stall to PC, IF/ID, ID/EX, EX/MEM.
- bus_err  out  1  sticky error flag.

Behaviour:
- Reset (synchronous, active-high, sampled on posedge clk): state=IDLE; mem_req, mem_we, ready, bus_err = 0; mem_addr, mem_wdata, MEM_read_value = 0; timeout counter = 0.
- Reset mid-transaction abandons the access; mem_req is low from the first post-reset cycle; a late mem_ack is ignored.
- Address map: word address = (ALU_result_in - BASE_ADDR) >> 2, truncated to ADDR_W bits. Addresses below BASE_ADDR wrap modulo 2^ADDR_W with no error.
- Access type: if both R and W enables are set, the read wins and the write is suppressed.

FSM states: IDLE, WAIT, DONE.

IDLE:
- No enable: freeze=0, ready=0, no transition.
- Enable with ALU_result_in[1:0]!=0 (misaligned): no request issued; bus_err<=1; MEM_read_value<=0; go to DONE; freeze=1 this cycle.
- Enable, aligned: latch mem_addr, mem_we=~R&W, mem_wdata=Val_Rm_in; mem_req<=1; counter<=0; go to WAIT; freeze=1 combinationally in this same cycle.

WAIT:
- freeze=1; mem_req, mem_we, mem_addr, mem_wdata held stable until ack.
- mem_ack: mem_req<=0. On a read, MEM_read_value<=mem_rdata; on a write, MEM_read_value is unchanged. Go to DONE.
- No ack: counter increments. When counter==TIMEOUT-1 with no ack: mem_req<=0, bus_err<=1, MEM_read_value<=0, go to DONE.
- An ack arriving on the timeout cycle counts as success.

DONE:
- freeze=0; ready=1 for exactly one cycle; the pipeline advances at the end of this cycle. Next state IDLE unconditionally.
- The EX/MEM contents seen during DONE belong to the completed instruction, so no re-issue occurs.
- mem_ack received outside WAIT is ignored.

General:
- bus_err is cleared only by rst.
- Latency, aligned access, ack after k cycles in WAIT (k>=1): freeze high for k+1 cycles; ready on cycle k+2 after the enable is first seen.
- Zero-enable cycles cost no extra latency.

Decomposition:
- Shared package mips_mem_pkg holds:
  - state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2);
  - DMEM_BASE=1024;
  - DMEM_ADDR_W;
  - bus_err code constants.
- Optional sub-module mem_timeout_cnt: loadable up-counter with terminal-count flag. Otherwise a single module.

Test Plan:
- Aligned load, ALU_result_in=1028, mem_rdata=32'hCAFE_0001, ack 3 cycles after req -> mem_addr=1, mem_we=0, freeze high 4 cycles, ready 1 cycle later with MEM_read_value=32'hCAFE_0001.
- Store, ALU_result_in=1032, Val_Rm_in=32'h1234, ack 1 cycle after req -> mem_we=1, mem_addr=2, mem_wdata=32'h1234 held until ack, MEM_read_value unchanged, bus_err=0.
- Misaligned load at 1030 -> mem_req stays 0, bus_err=1, ready next cycle, MEM_read_value=0.
- No ack with TIMEOUT=16 -> mem_req drops after 16 WAIT cycles, bus_err=1, ready=1, pipeline resumes.
- R and W enables both set at 1024 -> mem_we=0 (read performed), read value returned.
- rst asserted in the second WAIT cycle, then a late ack -> all outputs 0 the cycle after reset, late ack ignored, state IDLE.
